// File: rtl/cu_sequencer_if.sv
// cu_sequencer_if -- control bus between the instruction decoder and the
// micro-sequencer.
//   master : drives en, COUNTER_LD/INC/CLR, opcode; observes the state outputs
//   slave  : the sequencer itself
//   CPU_state  [states-1:0] one-hot current control state
//   state_idx  [5:0]        binary current control state
//   instr_done              one-cycle pulse after an instruction completes
//   illegal_op              one-cycle pulse after a load of an unmapped opcode
interface cu_sequencer_if #(
    parameter int states = 40
);
    logic              en;
    logic              COUNTER_LD;
    logic              COUNTER_INC;
    logic              COUNTER_CLR;
    logic [4:0]        opcode;
    logic [states-1:0] CPU_state;
    logic [5:0]        state_idx;
    logic              instr_done;
    logic              illegal_op;

    modport master (
        output en, COUNTER_LD, COUNTER_INC, COUNTER_CLR, opcode,
        input  CPU_state, state_idx, instr_done, illegal_op
    );

    modport slave (
        input  en, COUNTER_LD, COUNTER_INC, COUNTER_CLR, opcode,
        output CPU_state, state_idx, instr_done, illegal_op
    );
endinterface

// File: rtl/cu_sequencer.sv
// cu_sequencer -- one-hot control-state sequencer for the CPU control unit.
// Holds a registered 6-bit state index; the one-hot CPU_state is a pure decode
// of that register, so control inputs show up one edge after they are sampled.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset (index forced to fetch1 = 0)
//   bus  cu_sequencer_if.slave (controls in, state/pulses out)
module cu_sequencer #(
    parameter int states = 40
) (
    input  logic clk,
    input  logic rst,
    cu_sequencer_if.slave bus
);
    // Index is 6 bits wide, so states must not exceed 63.
    localparam logic [5:0] NUM_STATES = 6'(states);
    localparam logic [5:0] LAST_IDX   = 6'(states - 1);
    localparam logic [5:0] NOP1_IDX   = 6'd3;

    logic [5:0] idx;
    logic       done_q;
    logic       illegal_q;

    // Start index of each instruction routine; unmapped opcodes run nop1.
    function automatic logic [5:0] op_start(input logic [4:0] op);
        case (op)
            5'd0:    op_start = 6'd3;
            5'd1:    op_start = 6'd4;
            5'd2:    op_start = 6'd5;
            5'd3:    op_start = 6'd7;
            5'd4:    op_start = 6'd9;
            5'd5:    op_start = 6'd13;
            5'd6:    op_start = 6'd17;
            5'd7:    op_start = 6'd21;
            5'd8:    op_start = 6'd22;
            5'd9:    op_start = 6'd23;
            5'd10:   op_start = 6'd24;
            5'd11:   op_start = 6'd25;
            5'd12:   op_start = 6'd26;
            5'd13:   op_start = 6'd28;
            5'd14:   op_start = 6'd30;
            5'd15:   op_start = 6'd32;
            5'd16:   op_start = 6'd34;
            5'd17:   op_start = 6'd36;
            5'd18:   op_start = 6'd38;
            default: op_start = NOP1_IDX;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            if (idx >= NUM_STATES) begin
                // Corrupted index: recover to fetch1 even while disabled.
                idx <= '0;
            end else if (bus.en) begin
                if (bus.COUNTER_CLR) begin
                    idx    <= '0;
                    done_q <= (idx != 6'd0);
                end else if (bus.COUNTER_LD) begin
                    idx       <= op_start(bus.opcode);
                    illegal_q <= (bus.opcode > 5'd18);
                end else if (bus.COUNTER_INC) begin
                    idx <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
                end else if (idx == NOP1_IDX) begin
                    // nop finishes on its own without a CLR from the decoder.
                    idx    <= '0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Out-of-range indices present as fetch1 so CPU_state is never all-zero.
    always_comb begin
        bus.CPU_state = '0;
        for (int i = 0; i < states; i++)
            bus.CPU_state[i] = (idx == 6'(i));
        bus.CPU_state[0] = bus.CPU_state[0] | (idx >= NUM_STATES);
    end

    assign bus.state_idx  = idx;
    assign bus.instr_done = done_q;
    assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_cu_sequencer.sv
module tb_cu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cu_sequencer_if #(.states(40)) bus ();
    cu_sequencer #(.states(40)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        int   idx;
        logic done;
        logic ill;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    int exp_map[32] = '{3, 4, 5, 7, 9, 13, 17, 21, 22, 23, 24, 25, 26, 28, 30, 32,
                        34, 36, 38, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, want);
        end
    endtask

    // Drive one cycle of controls and record what the sequencer must show after the edge.
    task automatic step(input logic e, input logic clr, input logic ld, input logic inc,
                        input logic [4:0] op, input int xi, input logic xd, input logic xl);
        exp_t x;
        @(negedge clk);
        bus.en = e; bus.COUNTER_CLR = clr; bus.COUNTER_LD = ld;
        bus.COUNTER_INC = inc; bus.opcode = op;
        x.idx = xi; x.done = xd; x.ill = xl;
        q.push_back(x);
    endtask

    task automatic idle(input int xi, input logic xd);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, xi, xd, 1'b0);
    endtask

    // Monitor: every edge with an outstanding expectation is checked.
    always @(posedge clk) begin
        exp_t e;
        logic [39:0] oh;
        #1;
        if (q.size() > 0) begin
            e  = q.pop_front();
            oh = 40'd1 << e.idx;
            chk("state_idx", 64'(bus.state_idx), 64'(e.idx));
            chk("CPU_state", 64'(bus.CPU_state), 64'(oh));
            chk("instr_done", 64'(bus.instr_done), 64'(e.done));
            chk("illegal_op", 64'(bus.illegal_op), 64'(e.ill));
        end
    end

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            @(posedge clk); #2; n++;
        end
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d expected=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        bus.en = 1'b1; bus.COUNTER_CLR = 1'b0; bus.COUNTER_LD = 1'b0;
        bus.COUNTER_INC = 1'b0; bus.opcode = 5'd0;
        #1;
        chk("rst_idx", 64'(bus.state_idx), 64'd0);
        chk("rst_cpu_state", 64'(bus.CPU_state), 64'd1);
        chk("rst_done", 64'(bus.instr_done), 64'd0);
        chk("rst_ill", 64'(bus.illegal_op), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // fetch then add
        step(1, 0, 0, 1, 5'd0, 1, 0, 0);
        step(1, 0, 0, 1, 5'd0, 2, 0, 0);
        step(1, 0, 1, 0, 5'd12, 26, 0, 0);
        step(1, 0, 0, 1, 5'd0, 27, 0, 0);
        step(1, 1, 0, 0, 5'd0, 0, 1, 0);
        idle(0, 0);

        // nop from index 2
        step(1, 0, 0, 1, 5'd0, 1, 0, 0);
        step(1, 0, 0, 1, 5'd0, 2, 0, 0);
        step(1, 0, 1, 0, 5'd0, 3, 0, 0);
        idle(0, 1);
        idle(0, 0);

        // illegal opcode
        step(1, 0, 1, 0, 5'd25, 3, 0, 1);
        idle(0, 1);

        // priority
        step(1, 0, 0, 1, 5'd0, 1, 0, 0);
        step(1, 0, 0, 1, 5'd0, 2, 0, 0);
        step(1, 0, 1, 0, 5'd12, 26, 0, 0);
        step(1, 0, 0, 1, 5'd0, 27, 0, 0);
        step(1, 1, 1, 1, 5'd12, 0, 1, 0);
        step(1, 0, 0, 1, 5'd0, 1, 0, 0);
        step(1, 0, 0, 1, 5'd0, 2, 0, 0);
        step(1, 0, 1, 1, 5'd18, 38, 0, 0);

        // wrap, then CLR at index 0 gives no pulse
        step(1, 0, 0, 1, 5'd0, 39, 0, 0);
        step(1, 0, 0, 1, 5'd0, 0, 0, 0);
        step(1, 1, 0, 0, 5'd0, 0, 0, 0);

        // freeze at 14
        step(1, 0, 1, 0, 5'd5, 13, 0, 0);
        step(1, 0, 0, 1, 5'd0, 14, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 5'd0, 14, 0, 0);
        step(0, 1, 0, 0, 5'd0, 14, 0, 0);
        idle(14, 0);
        step(1, 1, 0, 0, 5'd0, 0, 1, 0);

        // full opcode map: load, then clear back to fetch1
        for (int op = 0; op < 32; op++) begin
            step(1, 0, 1, 0, 5'(op), exp_map[op], 0, (op > 18));
            step(1, 1, 0, 0, 5'd0, 0, 1, 0);
        end

        // async reset mid-routine at index 30
        step(1, 0, 1, 0, 5'd14, 30, 0, 0);
        idle(30, 0);
        drain();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_idx", 64'(bus.state_idx), 64'd0);
        chk("async_cpu_state", 64'(bus.CPU_state), 64'd1);
        chk("async_done", 64'(bus.instr_done), 64'd0);
        @(posedge clk); #1;
        chk("rst_hold_done", 64'(bus.instr_done), 64'd0);
        chk("rst_hold_idx", 64'(bus.state_idx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(0, 0);
        step(1, 0, 0, 1, 5'd0, 1, 0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
